// File: rtl/cell_draw_scheduler.sv
// cell_draw_scheduler
//   Sole owner of the render_box20 painter. After reset (or on clear_req) it
//   sweeps every board cell with BG_COLOR, then arbitrates two valid/ready
//   draw ports: A (active piece, high priority) and B (board repaint, low
//   priority, protected from starvation by an A burst limit). Cell
//   coordinates are turned into pixel origins before they reach the painter.
//
// Ports
//   CLOCK_50, resetn                 clock, async active-low reset
//   clear_req / clearing             sweep request pulse / sweep in progress
//   a_valid,a_ready,a_x,a_y,a_color  port A request (ready is combinational)
//   b_valid,b_ready,b_x,b_y,b_color  port B request (ready is combinational)
//   paint_start,paint_x0,paint_y0,paint_color  painter command
//   paint_done, paint_busy           painter status
//   range_err                        pulse: accepted request dropped (off board)
//   idle                             IDLE with no pending clear
module cell_draw_scheduler #(
  parameter int         COLS     = 10,
  parameter int         ROWS     = 20,
  parameter int         CELL_W   = 64,
  parameter int         CELL_H   = 24,
  parameter logic [8:0] BG_COLOR = 9'h000,
  parameter int         A_BURST  = 4
) (
  input  logic       CLOCK_50,
  input  logic       resetn,
  input  logic       clear_req,
  output logic       clearing,
  input  logic       a_valid,
  output logic       a_ready,
  input  logic [3:0] a_x,
  input  logic [4:0] a_y,
  input  logic [8:0] a_color,
  input  logic       b_valid,
  output logic       b_ready,
  input  logic [3:0] b_x,
  input  logic [4:0] b_y,
  input  logic [8:0] b_color,
  output logic       paint_start,
  output logic [9:0] paint_x0,
  output logic [8:0] paint_y0,
  output logic [8:0] paint_color,
  input  logic       paint_done,
  input  logic       paint_busy,
  output logic       range_err,
  output logic       idle
);

  localparam logic [2:0] S_CLR_ISSUE = 3'd0;
  localparam logic [2:0] S_CLR_WAIT  = 3'd1;
  localparam logic [2:0] S_IDLE      = 3'd2;
  localparam logic [2:0] S_ISSUE     = 3'd3;
  localparam logic [2:0] S_WAIT      = 3'd4;

  localparam int         BW      = $clog2(A_BURST + 1);
  localparam logic [BW-1:0] BURST_MAX = BW'(A_BURST);
  localparam logic [3:0] CX_LAST = 4'(COLS - 1);
  localparam logic [4:0] CY_LAST = 5'(ROWS - 1);

  typedef struct packed {
    logic [3:0] x;
    logic [4:0] y;
    logic [8:0] color;
  } cell_req_t;

  logic [2:0]    state;
  logic [3:0]    cx;
  logic [4:0]    cy;
  logic          clear_pend;
  logic [BW-1:0] burst;

  logic          grant_ok, b_force, a_hs, b_hs, in_range;
  cell_req_t     req;
  logic [9:0]    x0_calc;
  logic [8:0]    y0_calc;

  // A clear request in IDLE wins over both ports, so no handshake that cycle.
  assign grant_ok = (state == S_IDLE) && !paint_busy && !clear_pend && !clear_req;
  // B has waited through A_BURST consecutive A grants: B goes next.
  assign b_force  = b_valid && (burst == BURST_MAX);
  assign a_ready  = grant_ok && a_valid && !b_force;
  assign b_ready  = grant_ok && b_valid && (!a_valid || b_force);
  assign a_hs     = a_valid && a_ready;
  assign b_hs     = b_valid && b_ready;
  assign idle     = (state == S_IDLE) && !clear_pend;

  always_comb begin
    req = {a_x, a_y, a_color};
    if (b_hs) req = {b_x, b_y, b_color};
  end

  assign in_range = (32'(req.x) < COLS) && (32'(req.y) < ROWS);
  // Full output width products: 9*64 = 576 and 19*24 = 456 both fit.
  assign x0_calc  = 10'(req.x) * 10'(CELL_W);
  assign y0_calc  = 9'(req.y) * 9'(CELL_H);

  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) begin
      state       <= S_CLR_ISSUE;
      clearing    <= 1'b1;
      cx          <= '0;
      cy          <= '0;
      clear_pend  <= 1'b0;
      burst       <= '0;
      paint_start <= 1'b0;
      paint_x0    <= '0;
      paint_y0    <= '0;
      paint_color <= '0;
      range_err   <= 1'b0;
    end else begin
      paint_start <= 1'b0;
      range_err   <= 1'b0;

      if (!b_valid || b_hs)               burst <= '0;
      else if (a_hs && burst != BURST_MAX) burst <= burst + 1'b1;

      case (state)
        S_CLR_ISSUE: begin
          if (!paint_busy) begin
            paint_x0    <= 10'(cx) * 10'(CELL_W);
            paint_y0    <= 9'(cy) * 9'(CELL_H);
            paint_color <= BG_COLOR;
            paint_start <= 1'b1;
            state       <= S_CLR_WAIT;
          end
        end
        S_CLR_WAIT: begin
          if (paint_done) begin
            if (cx == CX_LAST) begin
              cx <= '0;
              if (cy == CY_LAST) begin
                cy       <= '0;
                clearing <= 1'b0;
                state    <= S_IDLE;
              end else begin
                cy    <= cy + 1'b1;
                state <= S_CLR_ISSUE;
              end
            end else begin
              cx    <= cx + 1'b1;
              state <= S_CLR_ISSUE;
            end
          end
        end
        S_IDLE: begin
          if (clear_req) begin
            clearing <= 1'b1;
            state    <= S_CLR_ISSUE;
          end else if (a_hs || b_hs) begin
            if (in_range) begin
              // Grant implies the painter is free, so start goes out next cycle.
              paint_x0    <= x0_calc;
              paint_y0    <= y0_calc;
              paint_color <= req.color;
              paint_start <= 1'b1;
              state       <= S_ISSUE;
            end else begin
              range_err <= 1'b1;
            end
          end
        end
        S_ISSUE: begin
          if (clear_req) clear_pend <= 1'b1;
          if (paint_start)     state       <= S_WAIT;
          else if (!paint_busy) paint_start <= 1'b1;
        end
        S_WAIT: begin
          if (paint_done) begin
            if (clear_pend || clear_req) begin
              clear_pend <= 1'b0;
              clearing   <= 1'b1;
              state      <= S_CLR_ISSUE;
            end else begin
              state <= S_IDLE;
            end
          end else if (clear_req) begin
            clear_pend <= 1'b1;
          end
        end
        default: state <= S_CLR_ISSUE;
      endcase
    end
  end

endmodule

// File: tb/tb_cell_draw_scheduler.sv
// Self-checking bench for cell_draw_scheduler: painter model with done three
// cycles after start, a monitor logging starts/grants, and directed plus
// randomized request sequences compared against plain-arithmetic expectations.
module tb_cell_draw_scheduler;
  localparam int COLS = 10, ROWS = 20, CELL_W = 64, CELL_H = 24, A_BURST = 4;

  logic clk = 1'b0, resetn = 1'b1, clear_req = 1'b0;
  logic a_valid = 1'b0, b_valid = 1'b0;
  logic [3:0] a_x = '0, b_x = '0;
  logic [4:0] a_y = '0, b_y = '0;
  logic [8:0] a_color = '0, b_color = '0;
  logic clearing, a_ready, b_ready, paint_start, range_err, idle;
  logic [9:0] paint_x0;
  logic [8:0] paint_y0, paint_color;
  logic p_busy, p_done;
  int   p_cnt;

  int tests = 0, fails = 0;

  cell_draw_scheduler dut (
    .CLOCK_50(clk), .resetn(resetn), .clear_req(clear_req), .clearing(clearing),
    .a_valid(a_valid), .a_ready(a_ready), .a_x(a_x), .a_y(a_y), .a_color(a_color),
    .b_valid(b_valid), .b_ready(b_ready), .b_x(b_x), .b_y(b_y), .b_color(b_color),
    .paint_start(paint_start), .paint_x0(paint_x0), .paint_y0(paint_y0),
    .paint_color(paint_color), .paint_done(p_done), .paint_busy(p_busy),
    .range_err(range_err), .idle(idle)
  );

  always #10 clk = ~clk;

  // Painter: takes a start when free, done pulse three cycles later.
  always @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      p_busy <= 1'b0; p_done <= 1'b0; p_cnt <= 0;
    end else begin
      p_done <= 1'b0;
      if (p_busy) begin
        if (p_cnt == 1) begin p_busy <= 1'b0; p_done <= 1'b1; end
        else p_cnt <= p_cnt - 1;
      end else if (paint_start) begin
        p_busy <= 1'b1; p_cnt <= 3;
      end
    end
  end

  // Monitor: log starts and grants, count range errors and protocol breaks.
  int st_x[$], st_y[$], st_c[$], grants[$];
  int n_rerr = 0, n_both = 0, n_hold = 0;
  logic [9:0] hx; logic [8:0] hy, hc;
  always @(negedge clk) begin
    if (resetn) begin
      if (paint_start) begin
        st_x.push_back(int'(paint_x0)); st_y.push_back(int'(paint_y0));
        st_c.push_back(int'(paint_color));
        hx = paint_x0; hy = paint_y0; hc = paint_color;
      end else if ((p_busy || p_done) &&
                   (paint_x0 != hx || paint_y0 != hy || paint_color != hc)) begin
        n_hold++;
      end
      if (range_err) n_rerr++;
      if (a_valid && a_ready) grants.push_back(0);
      if (b_valid && b_ready) grants.push_back(1);
      if (a_ready && b_ready) n_both++;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] want);
    tests++;
    assert (obs === want) else begin
      fails++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, want);
    end
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic send(input bit port_b, input int x, input int y, input int c, output int lat);
    string tg;
    tg = port_b ? "b_ready" : "a_ready";
    tick();
    if (port_b) begin b_valid = 1; b_x = 4'(x); b_y = 5'(y); b_color = 9'(c); end
    else        begin a_valid = 1; a_x = 4'(x); a_y = 5'(y); a_color = 9'(c); end
    lat = 0;
    @(negedge clk);
    while (!(port_b ? b_ready : a_ready) && lat < 100) begin @(negedge clk); lat++; end
    check(tg, 32'(port_b ? b_ready : a_ready), 1);
    tick();
    a_valid = 0; b_valid = 0;
  endtask

  task automatic wait_idle(input int bound);
    int n = 0;
    @(negedge clk);
    while (!idle && n < bound) begin @(negedge clk); n++; end
    check("idle_wait", 32'(idle), 1);
  endtask

  task automatic wait_clear_fall(input int bound);
    int n = 0;
    @(negedge clk);
    while (clearing && n < bound) begin @(negedge clk); n++; end
    check("clearing_fall", 32'(clearing), 0);
  endtask

  function automatic int at(input int q[$], input int i);
    return (i >= 0 && i < q.size()) ? q[i] : -1;
  endfunction

  initial begin
    int lat, s0, s1, g0, r0, n, bad, run, early, exp_err;
    int ax, ay, ac, bx, by, bc;
    int ex[$], ey[$], ec[$];

    // Reset state (valids high to show readies stay low)
    #3 resetn = 0;
    a_valid = 1; b_valid = 1;
    repeat (2) @(negedge clk);
    check("rst_clearing", 32'(clearing), 1);
    check("rst_start", 32'(paint_start), 0);
    check("rst_x0", 32'(paint_x0), 0);
    check("rst_y0", 32'(paint_y0), 0);
    check("rst_color", 32'(paint_color), 0);
    check("rst_range_err", 32'(range_err), 0);
    check("rst_idle", 32'(idle), 0);
    check("rst_a_ready", 32'(a_ready), 0);
    check("rst_b_ready", 32'(b_ready), 0);
    a_valid = 0; b_valid = 0;
    tick();
    resetn = 1;

    // Power-up sweep: 200 starts in row-major order
    wait_clear_fall(3000);
    check("sweep_starts", st_x.size(), 200);
    bad = 0;
    for (int i = 0; i < 200; i++)
      if (at(st_x, i) != (i % COLS) * CELL_W || at(st_y, i) != (i / COLS) * CELL_H ||
          at(st_c, i) != 0) bad++;
    check("sweep_order", bad, 0);
    check("sweep_last_x0", at(st_x, 199), 576);
    check("sweep_last_y0", at(st_y, 199), 456);
    @(negedge clk);
    check("idle_after_sweep", 32'(idle), 1);

    // Directed A draw
    s0 = st_x.size();
    send(0, 3, 5, 'h1C7, lat);
    check("a_ready_latency", lat, 0);
    @(negedge clk);
    check("a_start", 32'(paint_start), 1);
    check("a_x0", 32'(paint_x0), 3 * CELL_W);
    check("a_y0", 32'(paint_y0), 5 * CELL_H);
    check("a_color", 32'(paint_color), 'h1C7);
    wait_idle(50);
    check("a_one_start", st_x.size() - s0, 1);

    // Both ports held valid: starvation guard pattern
    ax = $urandom_range(0, COLS - 1); ay = $urandom_range(0, ROWS - 1); ac = $urandom_range(0, 511);
    bx = $urandom_range(0, COLS - 1); by = $urandom_range(0, ROWS - 1); bc = $urandom_range(0, 511);
    g0 = grants.size(); s0 = st_x.size();
    tick();
    a_valid = 1; a_x = 4'(ax); a_y = 5'(ay); a_color = 9'(ac);
    b_valid = 1; b_x = 4'(bx); b_y = 5'(by); b_color = 9'(bc);
    n = 0;
    while ((grants.size() - g0) < 10 && n < 500) begin @(negedge clk); n++; end
    tick();
    a_valid = 0; b_valid = 0;
    wait_idle(50);
    check("burst_grants", grants.size() - g0, 10);
    bad = 0; run = 0;
    for (int i = 0; i < 10; i++) begin
      int want_b;
      want_b = (run == A_BURST) ? 1 : 0;
      run = want_b ? 0 : run + 1;
      if (at(grants, g0 + i) != want_b) bad++;
      if (at(st_x, s0 + i) != (want_b ? bx : ax) * CELL_W ||
          at(st_y, s0 + i) != (want_b ? by : ay) * CELL_H ||
          at(st_c, s0 + i) != (want_b ? bc : ac)) bad++;
    end
    check("burst_order", bad, 0);

    // Out-of-range B, then a max-corner A
    r0 = n_rerr; s0 = st_x.size();
    send(1, 10, 2, 'h0AA, lat);
    @(negedge clk);
    check("rerr_pulse", 32'(range_err), 1);
    @(negedge clk);
    check("rerr_once", 32'(range_err), 0);
    check("rerr_idle", 32'(idle), 1);
    check("rerr_no_start", st_x.size() - s0, 0);
    check("rerr_count", n_rerr - r0, 1);
    send(0, 9, 19, 'h155, lat);
    @(negedge clk);
    check("max_start", 32'(paint_start), 1);
    check("max_x0", 32'(paint_x0), 576);
    check("max_y0", 32'(paint_y0), 456);
    wait_idle(50);

    // Randomized single requests, including off-board coordinates
    s0 = st_x.size(); r0 = n_rerr; exp_err = 0;
    for (int k = 0; k < 24; k++) begin
      int pb, rx, ry, rc;
      pb = $urandom_range(0, 1); rx = $urandom_range(0, 15);
      ry = $urandom_range(0, 31); rc = $urandom_range(0, 511);
      if (rx < COLS && ry < ROWS) begin
        ex.push_back(rx * CELL_W); ey.push_back(ry * CELL_H); ec.push_back(rc);
      end else exp_err++;
      send(pb[0], rx, ry, rc, lat);
      wait_idle(50);
    end
    check("rand_starts", st_x.size() - s0, ex.size());
    check("rand_rerr", n_rerr - r0, exp_err);
    bad = 0;
    foreach (ex[i])
      if (at(st_x, s0 + i) != ex[i] || at(st_y, s0 + i) != ey[i] || at(st_c, s0 + i) != ec[i]) bad++;
    check("rand_origins", bad, 0);

    // clear_req during WAIT: draw finishes, sweep, held A waits for the sweep
    s0 = st_x.size();
    send(0, 1, 1, 'h0F0, lat);
    tick();
    a_valid = 1; a_x = 4'd2; a_y = 5'd3; a_color = 9'h033;
    clear_req = 1;
    tick();
    clear_req = 0;
    @(negedge clk);
    check("pend_not_idle", 32'(idle), 0);
    early = 0; n = 0;
    while (!clearing && n < 50) begin
      @(negedge clk); n++;
      if (a_ready) early++;
    end
    check("pend_sweep_begins", 32'(clearing), 1);
    n = 0;
    while (n < 3000) begin
      @(negedge clk); n++;
      if (!clearing) break;
      if (a_ready) early++;
    end
    check("pend_sweep_ends", 32'(clearing), 0);
    check("pend_no_early_ready", early, 0);
    check("pend_ready_after", 32'(a_ready), 1);
    tick();
    a_valid = 0;
    wait_idle(50);
    check("pend_starts", st_x.size() - s0, 202);
    check("pend_first_bg_x0", at(st_x, s0 + 1), 0);
    check("pend_first_bg_c", at(st_c, s0 + 1), 0);
    check("pend_final_x0", at(st_x, s0 + 201), 2 * CELL_W);
    check("pend_final_y0", at(st_y, s0 + 201), 3 * CELL_H);

    // clear_req in IDLE beats a_valid; reset at cell 57 restarts the sweep
    s0 = st_x.size();
    tick();
    a_valid = 1; a_x = 4'd4; a_y = 5'd4; clear_req = 1;
    @(negedge clk);
    check("clr_beats_a", 32'(a_ready), 0);
    tick();
    clear_req = 0; a_valid = 0;
    n = 0;
    while ((st_x.size() - s0) < 57 && n < 1000) begin @(negedge clk); n++; end
    check("mid_reached_57", st_x.size() - s0, 57);
    tick();
    resetn = 0;
    @(negedge clk);
    check("mid_rst_start", 32'(paint_start), 0);
    check("mid_rst_clearing", 32'(clearing), 1);
    check("mid_rst_x0", 32'(paint_x0), 0);
    check("mid_rst_y0", 32'(paint_y0), 0);
    check("mid_rst_idle", 32'(idle), 0);
    tick();
    resetn = 1;
    s1 = st_x.size();
    wait_clear_fall(3000);
    check("restart_starts", st_x.size() - s1, 200);
    check("restart_x0", at(st_x, s1), 0);
    check("restart_y0", at(st_y, s1), 0);

    check("never_both_ready", n_both, 0);
    check("outputs_held", n_hold, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/cell_draw_scheduler.md
Name: cell_draw_scheduler

Overview:
- Owns the single render_box20 painter and sequences every cell-box draw into it.
- Runs a full-board background sweep after reset or on request.
- Arbitrates two requesters over valid/ready: port A (active piece erase/draw, high priority) and port B (board repaint after line clear, low priority), with a starvation guard for B.
- Converts cell coordinates to pixel origins. Sits between gamelogic/redraw logic and the painter.

Parameters:
COLS, 10, board width in cells
ROWS, 20, board height in cells
CELL_W, 64, cell width in pixels (x0 = x*CELL_W)
CELL_H, 24, cell height in pixels (y0 = y*CELL_H)
BG_COLOR, 9'h000, colour used by the clear sweep
A_BURST, 4, max consecutive A grants while B is pending

Ports:
CLOCK_50  in  1  system clock, 50 MHz
resetn  in  1  asynchronous active-low reset
clear_req  in  1  one-cycle pulse: request a full-board background sweep
clearing  out  1  high while a sweep is in progress
a_valid  in  1  port A request valid
a_ready  out  1  port A accept (combinational; handshake = a_valid & a_ready)
a_x  in  4  port A cell column
a_y  in  5  port A cell row
a_color  in  9  port A colour (RGB 3:3:3)
b_valid  in  1  port B request valid
b_ready  out  1  port B accept
b_x  in  4  port B cell column
b_y  in  5  port B cell row
b_color  in  9  port B colour
paint_start  out  1  one-cycle kick to the painter
paint_x0  out  10  pixel x origin
paint_y0  out  9  pixel y origin
paint_color  out  9  box colour
paint_done  in  1  painter finished pulse
paint_busy  in  1  painter busy level
range_err  out  1  one-cycle pulse: accepted request was out of range and was dropped
idle  out  1  high in IDLE with no pending clear

Behaviour:
- Reset is asynchronous and active-low. Reset values:
  - state = CLR_ISSUE, clearing = 1, sweep counters = 0
  - paint_start = 0, paint_x0 = 0, paint_y0 = 0, paint_color = 0
  - range_err = 0, idle = 0, a_ready = b_ready = 0
  - burst counter = 0, clear_pend = 0
- Reset asserted mid-operation aborts everything, including an in-flight draw, and restarts the sweep.
- States: CLR_ISSUE, CLR_WAIT, IDLE, ISSUE, WAIT.
- CLR_ISSUE:
  - When paint_busy = 0, load x0 = cx*CELL_W, y0 = cy*CELL_H, colour = BG_COLOR.
  - Pulse paint_start for exactly one cycle, then go to CLR_WAIT.
- CLR_WAIT:
  - On paint_done, advance cx first. At cx = COLS-1, wrap cx to 0 and increment cy.
  - At (COLS-1, ROWS-1): clear cy to 0, drop clearing, go to IDLE.
  - Otherwise return to CLR_ISSUE.
  - A sweep issues exactly COLS*ROWS = 200 starts.
- a_ready and b_ready are 0 in every state except IDLE.
- IDLE grant, evaluated while paint_busy = 0 and clear_pend = 0:
  - A is granted if a_valid, unless b_valid and burst = A_BURST, in which case B is granted.
  - Otherwise B is granted if b_valid.
  - At most one ready is high per cycle.
- Burst counter:
  - Increments on an A grant while b_valid is high, saturating at A_BURST.
  - Resets to 0 on any B grant or whenever b_valid is low.
- On a handshake (cycle T):
  - Register pixel origin and colour. Products are computed at full output width with no truncation: max x0 = 576, max y0 = 456.
  - Go to ISSUE. paint_start is high at T+1, provided paint_busy = 0; otherwise ISSUE holds until paint_busy = 0.
- Out-of-range request (x >= COLS or y >= ROWS):
  - Still handshaken.
  - No start is issued; range_err pulses at T+1 and the block stays in IDLE.
- ISSUE → WAIT after the start pulse. WAIT → IDLE on paint_done.
- paint_x0, paint_y0 and paint_color are held stable from the start pulse until paint_done.
- clear_req:
  - In IDLE: taken immediately; go to CLR_ISSUE with clearing = 1. Takes priority over a simultaneous a_valid/b_valid: no handshake that cycle.
  - In ISSUE or WAIT: sets clear_pend. The current draw completes, then the block enters CLR_ISSUE instead of IDLE.
  - During a sweep: ignored.
- paint_done outside CLR_WAIT/WAIT is ignored.
- idle = (state == IDLE) & ~clear_pend.

Test Plan:
- Release reset, painter model with done 3 cycles after start -> 200 paint_start pulses in row-major order (first (0,0), last x0=576,y0=456, colour 0); clearing falls after the 200th done; idle=1.
- Idle, A request (x=3,y=5,colour=9'h1C7) -> a_ready high the same cycle; paint_start next cycle with x0=192, y0=120, colour 9'h1C7; outputs held until done; back to IDLE.
- A and B both continuously valid -> grant order A,A,A,A,B,A,A,A,A,B; a_ready and b_ready never high together.
- B request x=10,y=2 -> handshake, no paint_start, range_err pulses once; a following valid A request draws normally.
- clear_req during WAIT of an A draw -> the A draw completes, then a full 200-cell sweep runs; a_valid held high is not accepted until clearing falls.
- resetn low for 1 cycle mid-sweep at cell 57 -> outputs return to reset values immediately; sweep restarts at (0,0).
